inbuf_wr_cntl: RTL and testbench

Write-side controller for the input buffer memory of the EC accelerator. It accepts host data beats, packs them into full memory lines, writes them into the input buffer as a circular buffer and tracks occupancy. The read-side controller downstream consumes one line per M compute cycles. This block gives it the next read address and line availability, and receives a pulse each time a line is fully consumed.

---
 rtl/inbuf_pkg.sv | 17 +
 rtl/inbuf_wr_cntl.sv | 147 ++++++++++++++
 tb/tb_inbuf_wr_cntl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inbuf_pkg.sv
// Shared constants and FSM state type for the EC accelerator input buffer write path.
package inbuf_pkg;

    localparam int HOST_DATA_W      = 64;
    localparam int INBUF_MEM_DATA_W = 512;
    localparam int INBUF_MEM_ADDR_W = 6;

    localparam int BEATS      = INBUF_MEM_DATA_W / HOST_DATA_W;
    localparam int DEPTH      = 1 << INBUF_MEM_ADDR_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } wr_state_e;

endpackage

// File: rtl/inbuf_wr_cntl.sv
// Input buffer write controller: packs host beats into memory lines and tracks circular occupancy.
// Define INBUF_WR_ERR_CHK_EN to enable the sticky protocol error flag (tied 0 otherwise).
module inbuf_wr_cntl #(
    parameter int HOST_DATA_W      = inbuf_pkg::HOST_DATA_W,
    parameter int INBUF_MEM_DATA_W = inbuf_pkg::INBUF_MEM_DATA_W,
    parameter int INBUF_MEM_ADDR_W = inbuf_pkg::INBUF_MEM_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          eng_rstn,
    input  logic [HOST_DATA_W-1:0]        host_wr_data,
    input  logic                          host_wr_val,
    input  logic                          host_wr_last,
    output logic                          host_wr_rdy,
    output logic                          inbuf_mem_wr_req,
    output logic [INBUF_MEM_ADDR_W-1:0]   inbuf_mem_wr_addr,
    output logic [INBUF_MEM_DATA_W-1:0]   inbuf_mem_wr_data,
    input  logic                          rd_line_done,
    output logic [INBUF_MEM_ADDR_W-1:0]   inbuf_rd_addr,
    output logic [INBUF_MEM_ADDR_W:0]     inbuf_lines_avail,
    output logic                          inbuf_empty,
    output logic                          inbuf_wr_err
);

    localparam int BEATS      = INBUF_MEM_DATA_W / HOST_DATA_W;
    localparam int DEPTH      = 1 << INBUF_MEM_ADDR_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int OCC_W      = INBUF_MEM_ADDR_W + 2;

    inbuf_pkg::wr_state_e                state_q, state_d;
    logic [BEAT_CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
    logic [INBUF_MEM_DATA_W-1:0]         pack_q, pack_d;
    logic [INBUF_MEM_DATA_W-1:0]         wr_data_q, wr_data_d;
    logic [INBUF_MEM_ADDR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [INBUF_MEM_ADDR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [INBUF_MEM_ADDR_W:0]           lines_avail_q, lines_avail_d;

    logic                                wr_req;
    logic                                accept;
    logic                                close_line;
    logic                                rd_ok;
    logic [OCC_W-1:0]                    occ_sum;
    logic [INBUF_MEM_DATA_W-1:0]         line_w;

    assign wr_req = (state_q == inbuf_pkg::COMMIT);

    // A line in COMMIT already owns a slot, so it counts against capacity before it lands in lines_avail.
    assign occ_sum     = OCC_W'(lines_avail_q) + OCC_W'(wr_req);
    assign host_wr_rdy = (occ_sum < OCC_W'(DEPTH));

    assign accept     = host_wr_val && host_wr_rdy;
    assign close_line = accept && ((beat_cnt_q == BEAT_CNT_W'(BEATS - 1)) || host_wr_last);
    assign rd_ok      = rd_line_done && (lines_avail_q != '0);

    always_comb begin
        line_w = pack_q;
        line_w[beat_cnt_q*HOST_DATA_W +: HOST_DATA_W] = host_wr_data;
    end

    always_comb begin
        state_d       = close_line ? inbuf_pkg::COMMIT : inbuf_pkg::FILL;
        beat_cnt_d    = beat_cnt_q;
        pack_d        = pack_q;
        wr_data_d     = wr_data_q;
        wr_ptr_d      = wr_ptr_q + INBUF_MEM_ADDR_W'(wr_req);
        rd_ptr_d      = rd_ptr_q + INBUF_MEM_ADDR_W'(rd_ok);
        lines_avail_d = lines_avail_q;

        if (close_line) begin
            wr_data_d  = line_w;
            pack_d     = '0;
            beat_cnt_d = '0;
        end else if (accept) begin
            pack_d     = line_w;
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        unique case ({wr_req, rd_ok})
            2'b10:   lines_avail_d = lines_avail_q + 1'b1;
            2'b01:   lines_avail_d = lines_avail_q - 1'b1;
            default: lines_avail_d = lines_avail_q;
        endcase

        if (!eng_rstn) begin
            state_d       = inbuf_pkg::FILL;
            beat_cnt_d    = '0;
            pack_d        = '0;
            wr_data_d     = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            lines_avail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= inbuf_pkg::FILL;
            beat_cnt_q    <= '0;
            pack_q        <= '0;
            wr_data_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            lines_avail_q <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            pack_q        <= pack_d;
            wr_data_q     <= wr_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            lines_avail_q <= lines_avail_d;
        end
    end

`ifdef INBUF_WR_ERR_CHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (rd_line_done && (lines_avail_q == '0))
              | (host_wr_val && !host_wr_rdy && host_wr_last);
        if (!eng_rstn) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign inbuf_wr_err = err_q;
`else
    assign inbuf_wr_err = 1'b0;
`endif

    assign inbuf_mem_wr_req  = wr_req;
    assign inbuf_mem_wr_addr = wr_ptr_q;
    assign inbuf_mem_wr_data = wr_data_q;
    assign inbuf_rd_addr     = rd_ptr_q;
    assign inbuf_lines_avail = lines_avail_q;
    assign inbuf_empty       = (lines_avail_q == '0);

endmodule

// File: tb/tb_inbuf_wr_cntl.sv
// Directed bench for inbuf_wr_cntl: packing, zero-fill, full stall, wrap and engine reset.
module tb_inbuf_wr_cntl;

    localparam int HW    = 64;
    localparam int LW    = 512;
    localparam int AW    = 6;
    localparam int LIMIT = 200;
`ifdef INBUF_WR_ERR_CHK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          eng_rstn;
    logic [HW-1:0] host_wr_data;
    logic          host_wr_val;
    logic          host_wr_last;
    logic          host_wr_rdy;
    logic          inbuf_mem_wr_req;
    logic [AW-1:0] inbuf_mem_wr_addr;
    logic [LW-1:0] inbuf_mem_wr_data;
    logic          rd_line_done;
    logic [AW-1:0] inbuf_rd_addr;
    logic [AW:0]   inbuf_lines_avail;
    logic          inbuf_empty;
    logic          inbuf_wr_err;

    int errors = 0;
    int checks = 0;
    logic [LW-1:0] exp_line;

    inbuf_wr_cntl dut (
        .clk               (clk),
        .rstn              (rstn),
        .eng_rstn          (eng_rstn),
        .host_wr_data      (host_wr_data),
        .host_wr_val       (host_wr_val),
        .host_wr_last      (host_wr_last),
        .host_wr_rdy       (host_wr_rdy),
        .inbuf_mem_wr_req  (inbuf_mem_wr_req),
        .inbuf_mem_wr_addr (inbuf_mem_wr_addr),
        .inbuf_mem_wr_data (inbuf_mem_wr_data),
        .rd_line_done      (rd_line_done),
        .inbuf_rd_addr     (inbuf_rd_addr),
        .inbuf_lines_avail (inbuf_lines_avail),
        .inbuf_empty       (inbuf_empty),
        .inbuf_wr_err      (inbuf_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        host_wr_val  = 1'b0;
        host_wr_last = 1'b0;
        rd_line_done = 1'b0;
    endtask

    // Presents one beat and returns right after the edge that accepts it; val stays high.
    task automatic send_beat(input logic [HW-1:0] data, input logic last, input logic rd);
        int n;
        n = 0;
        host_wr_val  = 1'b1;
        host_wr_data = data;
        host_wr_last = last;
        rd_line_done = rd;
        while (!host_wr_rdy && n < LIMIT) begin
            tick();
            rd_line_done = 1'b0;
            n++;
        end
        check("rdy_wait_bound", LW'(n < LIMIT), LW'(1));
        tick();
        rd_line_done = 1'b0;
    endtask

    task automatic eng_reset();
        idle();
        eng_rstn = 1'b0;
        tick();
        eng_rstn = 1'b1;
    endtask

    initial begin
        rstn         = 1'b0;
        eng_rstn     = 1'b1;
        host_wr_data = '0;
        idle();
        #23;
        rstn = 1'b1;
        tick();

        // Reset values
        check("rst_rdy",     LW'(host_wr_rdy),       LW'(1));
        check("rst_wr_req",  LW'(inbuf_mem_wr_req),  LW'(0));
        check("rst_wr_addr", LW'(inbuf_mem_wr_addr), LW'(0));
        check("rst_wr_data", inbuf_mem_wr_data,      LW'(0));
        check("rst_rd_addr", LW'(inbuf_rd_addr),     LW'(0));
        check("rst_avail",   LW'(inbuf_lines_avail), LW'(0));
        check("rst_empty",   LW'(inbuf_empty),       LW'(1));
        check("rst_err",     LW'(inbuf_wr_err),      LW'(0));

        // Full 8-beat line 0x1..0x8
        for (int b = 0; b < 8; b++) begin
            send_beat(HW'(b + 1), 1'b0, 1'b0);
            if (b == 6) check("full_no_early_req", LW'(inbuf_mem_wr_req), LW'(0));
        end
        exp_line = '0;
        for (int b = 0; b < 8; b++) exp_line[b*HW +: HW] = HW'(b + 1);
        check("full_wr_req",  LW'(inbuf_mem_wr_req),  LW'(1));
        check("full_wr_addr", LW'(inbuf_mem_wr_addr), LW'(0));
        check("full_wr_data", inbuf_mem_wr_data,      exp_line);
        check("full_avail_during_req", LW'(inbuf_lines_avail), LW'(0));
        idle();
        tick();
        check("full_avail_after", LW'(inbuf_lines_avail), LW'(1));
        check("full_req_drop",    LW'(inbuf_mem_wr_req),  LW'(0));
        check("full_not_empty",   LW'(inbuf_empty),       LW'(0));

        // Short line closed by last on 3rd beat, upper bits zero
        send_beat(64'hA1, 1'b0, 1'b0);
        send_beat(64'hA2, 1'b0, 1'b0);
        send_beat(64'hA3, 1'b1, 1'b0);
        exp_line = '0;
        exp_line[191:0] = {64'hA3, 64'hA2, 64'hA1};
        check("short_wr_req",  LW'(inbuf_mem_wr_req),  LW'(1));
        check("short_wr_addr", LW'(inbuf_mem_wr_addr), LW'(1));
        check("short_wr_data", inbuf_mem_wr_data,      exp_line);
        send_beat(64'hB0, 1'b1, 1'b0);
        check("next_wr_addr", LW'(inbuf_mem_wr_addr), LW'(2));
        check("next_wr_data", inbuf_mem_wr_data,      LW'(64'hB0));
        idle();
        tick();
        check("short_avail", LW'(inbuf_lines_avail), LW'(3));

        // Fill all 64 slots with single-beat lines, then stall
        eng_reset();
        check("eng_avail_zero", LW'(inbuf_lines_avail), LW'(0));
        for (int i = 0; i < 64; i++) send_beat(HW'(i), 1'b1, 1'b0);
        check("fill_rdy_drop",  LW'(host_wr_rdy),       LW'(0));
        check("fill_last_req",  LW'(inbuf_mem_wr_req),  LW'(1));
        check("fill_last_addr", LW'(inbuf_mem_wr_addr), LW'(63));
        host_wr_val  = 1'b1;
        host_wr_data = 64'h65;
        host_wr_last = 1'b1;
        tick();
        tick();
        tick();
        check("stall_rdy",   LW'(host_wr_rdy),       LW'(0));
        check("stall_avail", LW'(inbuf_lines_avail), LW'(64));
        check("stall_noreq", LW'(inbuf_mem_wr_req),  LW'(0));
        check("stall_err",   LW'(inbuf_wr_err),      LW'(ERR_EN));
        rd_line_done = 1'b1;
        tick();
        rd_line_done = 1'b0;
        check("release_rdy",     LW'(host_wr_rdy),       LW'(1));
        check("release_avail",   LW'(inbuf_lines_avail), LW'(63));
        check("release_rd_addr", LW'(inbuf_rd_addr),     LW'(1));
        tick();
        check("stalled_req",  LW'(inbuf_mem_wr_req),  LW'(1));
        check("stalled_addr", LW'(inbuf_mem_wr_addr), LW'(0));
        check("stalled_data", inbuf_mem_wr_data,      LW'(64'h65));
        idle();
        tick();
        check("refull_avail", LW'(inbuf_lines_avail), LW'(64));
        check("refull_rdy",   LW'(host_wr_rdy),       LW'(0));

        // Simultaneous write commit and consume at lines_avail=5
        eng_reset();
        check("eng_err_clear", LW'(inbuf_wr_err), LW'(0));
        for (int i = 0; i < 5; i++) send_beat(HW'(8'hC0 + i), 1'b1, 1'b0);
        idle();
        tick();
        check("five_avail", LW'(inbuf_lines_avail), LW'(5));
        send_beat(64'hC5, 1'b1, 1'b0);
        check("both_req_addr", LW'(inbuf_mem_wr_addr), LW'(5));
        host_wr_val  = 1'b0;
        rd_line_done = 1'b1;
        tick();
        rd_line_done = 1'b0;
        check("both_avail",   LW'(inbuf_lines_avail), LW'(5));
        check("both_wr_addr", LW'(inbuf_mem_wr_addr), LW'(6));
        check("both_rd_addr", LW'(inbuf_rd_addr),     LW'(1));

        // 70-line stream with a consumer, wrapping the write pointer
        eng_reset();
        for (int l = 0; l < 70; l++) begin
            exp_line = '0;
            for (int b = 0; b < 8; b++) begin
                exp_line[b*HW +: HW] = HW'((l << 16) | b);
                send_beat(HW'((l << 16) | b), 1'b0, (b == 3) && (l >= 1));
            end
            check($sformatf("stream_addr_%0d", l), LW'(inbuf_mem_wr_addr), LW'(l % 64));
            check($sformatf("stream_data_%0d", l), inbuf_mem_wr_data,      exp_line);
        end
        idle();
        tick();
        check("stream_avail",   LW'(inbuf_lines_avail), LW'(1));
        check("stream_wr_addr", LW'(inbuf_mem_wr_addr), LW'(6));
        check("stream_rd_addr", LW'(inbuf_rd_addr),     LW'(5));

        // Engine reset in the middle of a line
        for (int b = 0; b < 4; b++) send_beat(HW'(8'hD0 + b), 1'b0, 1'b0);
        host_wr_data = 64'hD4;
        eng_rstn = 1'b0;
        tick();
        eng_rstn = 1'b1;
        idle();
        check("mid_noreq",   LW'(inbuf_mem_wr_req),  LW'(0));
        check("mid_wr_addr", LW'(inbuf_mem_wr_addr), LW'(0));
        check("mid_rd_addr", LW'(inbuf_rd_addr),     LW'(0));
        check("mid_avail",   LW'(inbuf_lines_avail), LW'(0));
        check("mid_empty",   LW'(inbuf_empty),       LW'(1));
        check("mid_rdy",     LW'(host_wr_rdy),       LW'(1));
        tick();
        check("mid_noreq_later", LW'(inbuf_mem_wr_req), LW'(0));

        // Consume on empty: ignored, error flag sticky when enabled
        rd_line_done = 1'b1;
        tick();
        rd_line_done = 1'b0;
        check("empty_rd_addr", LW'(inbuf_rd_addr),     LW'(0));
        check("empty_avail",   LW'(inbuf_lines_avail), LW'(0));
        check("empty_err",     LW'(inbuf_wr_err),      LW'(ERR_EN));
        tick();
        tick();
        check("empty_err_sticky", LW'(inbuf_wr_err), LW'(ERR_EN));

        // Fresh line after the discard starts at beat 0, address 0
        exp_line = '0;
        for (int b = 0; b < 8; b++) begin
            exp_line[b*HW +: HW] = HW'(8'hE0 + b);
            send_beat(HW'(8'hE0 + b), 1'b0, 1'b0);
        end
        check("fresh_wr_addr", LW'(inbuf_mem_wr_addr), LW'(0));
        check("fresh_wr_data", inbuf_mem_wr_data,      exp_line);
        eng_reset();
        check("final_err_clear", LW'(inbuf_wr_err),      LW'(0));
        check("final_avail",     LW'(inbuf_lines_avail), LW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
